// File: rtl/mont_pkg.sv
// +----------------------------------------------------------------------------+
// | mont_pkg : shared widths and FSM encoding for the Montgomery exponentiator |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mont_pkg;

  localparam int MONT_NBITS = 512;
  localparam int MONT_LENW  = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TOMONT   = 3'd1,
    ST_SQUARE   = 3'd2,
    ST_MULT     = 3'd3,
    ST_FROMMONT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mont_exp_ctrl.sv
// +----------------------------------------------------------------------------+
// | mont_exp_ctrl : left-to-right X^E mod M sequencer driving an external      |
// | Montgomery multiplier. MONT_EXP_CONST_TIME_EN: multiply on every bit.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int NBITS = MONT_NBITS,
  parameter int LENW  = MONT_LENW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [NBITS-1:0] in_msg,
  input  logic [NBITS-1:0] in_exp,
  input  logic [LENW-1:0]  exp_len,
  input  logic [NBITS-1:0] in_m,
  input  logic [NBITS-1:0] in_r,
  input  logic [NBITS-1:0] in_r2,
  output logic             mont_start,
  output logic [NBITS-1:0] mont_a,
  output logic [NBITS-1:0] mont_b,
  output logic [NBITS-1:0] mont_m,
  input  logic [NBITS-1:0] mont_result,
  input  logic             mont_done,
  output logic [NBITS-1:0] result,
  output logic             done
);

  state_e           state_q, state_d;
  logic [NBITS-1:0] msg_q, msg_d;
  logic [NBITS-1:0] exp_q, exp_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [NBITS-1:0] m_q, m_d;
  logic [NBITS-1:0] r_q, r_d;
  logic [NBITS-1:0] r2_q, r2_d;
  logic [NBITS-1:0] xm_q, xm_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [LENW-1:0]  idx_q, idx_d;
  logic             pend_q, pend_d;
  logic             mstart_q, mstart_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic             w_cap;
  logic             w_bit;
  logic             w_last;

  // A result is only accepted while an operation is outstanding.
  assign w_cap  = pend_q & mont_done;
  assign w_bit  = |(exp_q & (NBITS'(1) << idx_q));
  assign w_last = (idx_q == '0);

  assign mont_start = mstart_q;
  assign mont_m     = m_q;
  assign result     = result_q;
  assign done       = done_q;

  // Operands follow state and accumulator, which only move after mont_done.
  always_comb begin
    mont_a = '0;
    mont_b = '0;
    case (state_q)
      ST_TOMONT:   begin mont_a = msg_q; mont_b = r2_q;         end
      ST_SQUARE:   begin mont_a = acc_q; mont_b = acc_q;        end
      ST_MULT:     begin mont_a = acc_q; mont_b = xm_q;         end
      ST_FROMMONT: begin mont_a = acc_q; mont_b = NBITS'(1);    end
      default:     begin mont_a = '0;    mont_b = '0;           end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    exp_d    = exp_q;
    len_d    = len_q;
    m_d      = m_q;
    r_d      = r_q;
    r2_d     = r2_q;
    xm_d     = xm_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    mstart_d = 1'b0;
    result_d = result_q;
    done_d   = 1'b0;

    // Each operation state issues once on entry, then waits for mont_done.
    if ((state_q inside {ST_TOMONT, ST_SQUARE, ST_MULT, ST_FROMMONT}) && !pend_q) begin
      mstart_d = 1'b1;
      pend_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          msg_d   = in_msg;
          exp_d   = in_exp;
          len_d   = (int'(exp_len) > NBITS) ? LENW'(NBITS) : exp_len;
          m_d     = in_m;
          r_d     = in_r;
          r2_d    = in_r2;
          state_d = ST_TOMONT;
        end
      end
      ST_TOMONT: begin
        if (w_cap) begin
          xm_d  = mont_result;
          acc_d = r_q;
          if (len_q == '0) begin
            state_d = ST_FROMMONT;
          end else begin
            idx_d   = len_q - LENW'(1);
            state_d = ST_SQUARE;
          end
        end
      end
      ST_SQUARE: begin
        if (w_cap) begin
          acc_d = mont_result;
`ifdef MONT_EXP_CONST_TIME_EN
          state_d = ST_MULT;
`else
          if (w_bit) begin
            state_d = ST_MULT;
          end else if (w_last) begin
            state_d = ST_FROMMONT;
          end else begin
            idx_d = idx_q - LENW'(1);
          end
`endif
        end
      end
      ST_MULT: begin
        if (w_cap) begin
`ifdef MONT_EXP_CONST_TIME_EN
          // Dummy multiply for zero bits: product is computed then dropped.
          if (w_bit) acc_d = mont_result;
`else
          acc_d = mont_result;
`endif
          if (w_last) begin
            state_d = ST_FROMMONT;
          end else begin
            idx_d   = idx_q - LENW'(1);
            state_d = ST_SQUARE;
          end
        end
      end
      ST_FROMMONT: begin
        if (w_cap) begin
          result_d = mont_result;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (w_cap) pend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      msg_q    <= '0;
      exp_q    <= '0;
      len_q    <= '0;
      m_q      <= '0;
      r_q      <= '0;
      r2_q     <= '0;
      xm_q     <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      mstart_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      exp_q    <= exp_d;
      len_q    <= len_d;
      m_q      <= m_d;
      r_q      <= r_d;
      r2_q     <= r2_d;
      xm_q     <= xm_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      mstart_q <= mstart_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mont_exp_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mont_exp_ctrl : scoreboard bench with a variable-latency Montgomery stub |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mont_exp_ctrl;

  localparam int NB = 512;
  localparam int LW = 10;

  typedef logic [NB-1:0] word_t;
  typedef struct {
    word_t res;
    int    pulses;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic          start;
  word_t         in_msg, in_exp, in_m, in_r, in_r2;
  logic [LW-1:0] exp_len;
  logic          mont_start;
  word_t         mont_a, mont_b, mont_m, mont_result;
  logic          mont_done;
  word_t         result;
  logic          done;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  int   pulse_cnt = 0;

  mont_exp_ctrl #(.NBITS(NB), .LENW(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_msg(in_msg), .in_exp(in_exp), .exp_len(exp_len),
    .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_result(mont_result), .mont_done(mont_done),
    .result(result), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // a*b*2^-NB mod m, bit-serial
  function automatic word_t f_mont(word_t a, word_t b, word_t m);
    logic [NB+1:0] t;
    t = '0;
    for (int i = 0; i < NB; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[NB-1:0];
  endfunction

  function automatic word_t f_pow2mod(word_t m, int n);
    logic [NB:0] r;
    r = 1;
    for (int i = 0; i < n; i++) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[NB-1:0];
  endfunction

  function automatic word_t f_modmul(word_t a, word_t b, word_t m);
    logic [NB:0] r;
    r = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
      if (b[i]) begin
        r = r + {1'b0, a};
        if (r >= {1'b0, m}) r = r - {1'b0, m};
      end
    end
    return r[NB-1:0];
  endfunction

  function automatic word_t f_modexp(word_t x, word_t e, int len, word_t m);
    word_t acc;
    acc = 1;
    for (int i = len - 1; i >= 0; i--) begin
      acc = f_modmul(acc, acc, m);
      if (e[i]) acc = f_modmul(acc, x, m);
    end
    return acc;
  endfunction

  function automatic int f_pulses(word_t e, int len);
    int n;
    int l;
    n = 2;
    l = (len > NB) ? NB : len;
    for (int i = 0; i < l; i++) begin
`ifdef MONT_EXP_CONST_TIME_EN
      n += 2;
`else
      n += 1 + int'(e[i]);
`endif
    end
    return n;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < NB / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic check_w(string name, word_t got, word_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  task automatic check_i(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pulse_cnt = 0;
      end else begin
        if (mont_start) pulse_cnt++;
        if (done) begin
          n_done++;
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done got=done(result=%0h) required=no_done", result);
          end else begin
            e = q.pop_front();
            check_w("result", result, e.res);
            check_i("mont_start_pulses", pulse_cnt, e.pulses);
          end
          pulse_cnt = 0;
        end
      end
    end
  end

  // Multiplier stub: random 1-20 cycle latency, checks operand hold.
  initial begin : stub
    logic  busy;
    logic  ok;
    int    cnt;
    word_t ca, cb, cm, pa, pb, pm;
    busy = 1'b0; ok = 1'b1; cnt = 0;
    ca = '0; cb = '0; cm = '0; pa = '0; pb = '0; pm = '0;
    mont_done = 1'b0;
    mont_result = '0;
    forever begin
      @(posedge clk);
      #1;
      mont_done = 1'b0;
      if (!resetn) begin
        busy = 1'b0;
      end else if (busy) begin
        ok = ok && (mont_a == ca) && (mont_b == cb) && (mont_m == cm) && !mont_start;
        if (cnt <= 1) begin
          mont_done   = 1'b1;
          mont_result = f_mont(ca, cb, cm);
          busy = 1'b0;
          n_tests++;
          if (!ok) begin
            n_fail++;
            $display("FAIL operand_hold got=changed_or_restarted required=stable");
          end
        end else begin
          cnt--;
        end
      end else if (mont_start) begin
        ca = mont_a; cb = mont_b; cm = mont_m;
        ok = (pa == ca) && (pb == cb) && (pm == cm);
        busy = 1'b1;
        cnt = int'($urandom_range(1, 20));
      end
      pa = mont_a; pb = mont_b; pm = mont_m;
    end
  end

  task automatic issue(word_t x, word_t e, int len, word_t m);
    @(negedge clk);
    in_msg  = x;
    in_exp  = e;
    exp_len = LW'(len);
    in_m    = m;
    in_r    = f_pow2mod(m, NB);
    in_r2   = f_pow2mod(m, 2 * NB);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    in_msg  = rand_word();
    in_exp  = rand_word();
    in_m    = rand_word();
    in_r    = rand_word();
    in_r2   = rand_word();
    exp_len = LW'($urandom());
  endtask

  task automatic wait_done(int target, string name);
    int k;
    k = 0;
    while (n_done < target && k < 40000) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (n_done < target) begin
      n_fail++;
      $display("FAIL %s_timeout got=%0d dones required=%0d", name, n_done, target);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic run_op(word_t x, word_t e, int len, word_t m, word_t want, string name);
    int target;
    target = n_done + 1;
    q.push_back('{res: want, pulses: f_pulses(e, len)});
    issue(x, e, len, m);
    wait_done(target, name);
  endtask

  task automatic wait_pulses(int n, string name);
    int k;
    k = 0;
    while (pulse_cnt < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (pulse_cnt < n) begin
      n_fail++;
      $display("FAIL %s_pulse_wait got=%0d required=%0d", name, pulse_cnt, n);
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog got=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    word_t rm, rx, re;
    int    target;
    resetn = 1'b0; start = 1'b0;
    in_msg = '0; in_exp = '0; exp_len = '0; in_m = '0; in_r = '0; in_r2 = '0;
    repeat (3) @(negedge clk);
    check_w("reset_result", result, '0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_mont_start", int'(mont_start), 0);
    check_w("reset_mont_m", mont_m, '0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run_op(2, 5, 3, 13, 6, "x2_e5");
    run_op(9, 'h1234, 0, 13, 1, "len0");
    run_op(4, 1, 1, 13, 4, "len1");
    run_op(12, 3, 2, 13, 12, "x_m_minus1");
    run_op(5, 12, 6, 13, 1, "leading_zeros");
    run_op(2, 3, 700, 13, 8, "len_clamp");

    // start re-pulsed after the first SQUARE has been issued
    target = n_done + 1;
    q.push_back('{res: 2, pulses: f_pulses(11, 4)});
    issue(7, 11, 4, 13);
    wait_pulses(2, "restart");
    issue(2, 5, 3, 13);
    wait_done(target, "restart");

    // reset while an operation is outstanding
    issue(5, 7, 3, 13);
    wait_pulses(1, "abort");
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check_w("abort_result", result, '0);
    check_i("abort_done", int'(done), 0);
    check_i("abort_mont_start", int'(mont_start), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    run_op(3, 4, 3, 13, 3, "after_abort");

    rm = rand_word();
    rm[0] = 1'b1;
    rm[NB-1] = 1'b1;
    rx = rand_word();
    rx[NB-1] = 1'b0;
    re = rand_word();
    run_op(rx, re, NB, rm, f_modexp(rx, re, NB, rm), "random512");

    check_i("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
